// File: rtl/swan128_pkg.sv
// Shared constants and types for the SWAN128 round-key generator.
//   KEY_SIZE/SIDE_SIZE : master key and subkey widths
//   PD                 : key-schedule rotation distance
//   DELTA0             : per-step delta increment
//   ROUNDS_DEF/RW_DEF  : default subkey count and round-index width
//   state_e            : generator FSM encoding
package swan128_pkg;

    localparam int unsigned KEY_SIZE   = 128;
    localparam int unsigned SIDE_SIZE  = 64;
    localparam int unsigned PD         = 56;
    localparam int unsigned ROUNDS_DEF = 48;
    localparam int unsigned RW_DEF     = 8;

    localparam logic [SIDE_SIZE-1:0] DELTA0 = 64'h9e3779b97f4a7c15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/enc_key_schedule_128.sv
// One combinational SWAN128 key-schedule step.
//   key        : current 128-bit key state (bit 0 = MSB)
//   delta      : current 64-bit delta accumulator
//   next_key   : key state after this step
//   next_delta : delta + DELTA0
//   sk         : subkey produced by this step
module enc_key_schedule_128
    import swan128_pkg::*;
(
    input  logic [0:KEY_SIZE-1]  key,
    input  logic [0:SIDE_SIZE-1] delta,
    output logic [0:KEY_SIZE-1]  next_key,
    output logic [0:SIDE_SIZE-1] next_delta,
    output logic [0:SIDE_SIZE-1] sk
);

    logic [0:KEY_SIZE-1] k0;

    // Rotate right by PD: the low PD bits move to the top.
    assign k0         = {key[KEY_SIZE-PD:KEY_SIZE-1], key[0:KEY_SIZE-PD-1]};
    assign next_delta = delta + DELTA0;
    assign sk         = k0[SIDE_SIZE:KEY_SIZE-1] + next_delta;
    assign next_key   = {k0[0:SIDE_SIZE-1], sk};

endmodule

// File: rtl/swan128_round_key_gen.sv
// SWAN128 sequential round-key generator: latches a master key and streams
// ROUNDS subkeys over a valid/ready handshake, with replay of the last key.
// Optional feature macro: SWAN128_SK_CACHE_EN (replay served from a subkey
// cache instead of recomputing the schedule; port behaviour is identical).
//   clk, rst_n             : clock, asynchronous active-low reset
//   load_valid/load_ready  : master key handshake, key_in = master key
//   sk_valid/sk_ready      : subkey handshake, sk_out = subkey
//   sk_round, sk_last      : index of the subkey on sk_out, final-subkey flag
//   replay                 : pulse in DONE to re-stream the last key
//   busy                   : stream in progress
module swan128_round_key_gen
    import swan128_pkg::*;
#(
    parameter int unsigned ROUNDS = ROUNDS_DEF,
    parameter int unsigned RW     = RW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [0:KEY_SIZE-1]  key_in,
    output logic                 sk_valid,
    input  logic                 sk_ready,
    output logic [0:SIDE_SIZE-1] sk_out,
    output logic [RW-1:0]        sk_round,
    output logic                 sk_last,
    input  logic                 replay,
    output logic                 busy
);

    state_e                 state_q;
    logic [0:KEY_SIZE-1]    key_q;
    logic [0:KEY_SIZE-1]    mkey_q;
    logic [0:SIDE_SIZE-1]   delta_q;
    logic [RW-1:0]          round_q;

    logic [0:KEY_SIZE-1]    next_key_d;
    logic [0:SIDE_SIZE-1]   next_delta_d;
    logic [0:SIDE_SIZE-1]   sk_d;
    logic [0:SIDE_SIZE-1]   sk_sel;

    logic run;
    logic load_acc;
    logic replay_acc;
    logic sk_hs;
    logic last_round;

    assign run        = (state_q == RUN);
    assign load_acc   = load_valid && !run;
    assign replay_acc = replay && (state_q == DONE);
    assign sk_hs      = run && sk_ready;
    assign last_round = (round_q == RW'(ROUNDS - 1));

    enc_key_schedule_128 u_step (
        .key        (key_q),
        .delta      (delta_q),
        .next_key   (next_key_d),
        .next_delta (next_delta_d),
        .sk         (sk_d)
    );

`ifdef SWAN128_SK_CACHE_EN
    localparam int unsigned CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    logic                 replay_q;
    logic [0:SIDE_SIZE-1] cache_q [ROUNDS];

    // Marks a stream that is being served from the cache.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            replay_q <= 1'b0;
        end else if (load_acc) begin
            replay_q <= 1'b0;
        end else if (replay_acc) begin
            replay_q <= 1'b1;
        end
    end

    // Capture each subkey of a load-initiated stream as it is consumed.
    always_ff @(posedge clk) begin
        if (sk_hs && !replay_q) begin
            cache_q[CW'(round_q)] <= sk_d;
        end
    end

    assign sk_sel = replay_q ? cache_q[CW'(round_q)] : sk_d;
`else
    localparam logic replay_q = 1'b0;

    assign sk_sel = sk_d;
`endif

    // FSM and key/delta/round state; load wins over a coincident replay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            mkey_q  <= '0;
            delta_q <= '0;
            round_q <= '0;
        end else if (load_acc) begin
            state_q <= RUN;
            key_q   <= key_in;
            mkey_q  <= key_in;
            delta_q <= '0;
            round_q <= '0;
        end else if (replay_acc) begin
            state_q <= RUN;
            key_q   <= mkey_q;
            delta_q <= '0;
            round_q <= '0;
        end else if (sk_hs) begin
            // A cached replay needs no schedule stepping.
            if (!replay_q) begin
                key_q   <= next_key_d;
                delta_q <= next_delta_d;
            end
            if (last_round) begin
                state_q <= DONE;
                round_q <= '0;
            end else begin
                round_q <= round_q + RW'(1);
            end
        end
    end

    // Outputs decode directly from registered state; sk_out is forced to
    // zero outside RUN so idle/reset values are deterministic.
    assign load_ready = !run;
    assign sk_valid   = run;
    assign busy       = run;
    assign sk_out     = run ? sk_sel : '0;
    assign sk_round   = round_q;
    assign sk_last    = run && last_round;

endmodule
